pid_ref_sequencer: RTL and testbench

// Sequences the digital PID loop: soft-starts the reference N_ref from 0 to
// the nominal value, then runs periodic load/reference transient events, and

---
 rtl/pid_ctrl_pkg.sv | 32 +++
 rtl/ov_debounce.sv | 57 +++++
 rtl/pid_ref_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pid_ref_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_ctrl_pkg.sv
// Shared definitions for the digital PID control loop.
//   - Q_W            : width of the signed reference/ADC code format
//   - seq_state_e    : sequencer state encoding (also exported on the debug port)
//   - *_DEF          : default sequencer constants shared with the PID datapath
//   - sat10()        : clamp an 11-bit signed intermediate into the 10-bit code range
package pid_ctrl_pkg;

  localparam int Q_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_REGULATE  = 3'd2,
    ST_FAULT     = 3'd3
  } seq_state_e;

  localparam logic signed [Q_W-1:0] RAMP_STEP_DEF = 10'sd2;
  localparam int                    N_TRAN_DEF    = 100;
  localparam logic signed [Q_W-1:0] OV_LIMIT_DEF  = 10'sd400;
  localparam int                    OV_COUNT_DEF  = 4;

  function automatic logic signed [Q_W-1:0] sat10(input logic signed [Q_W:0] x);
    if (x > 11'sd511) begin
      return {1'b0, {(Q_W-1){1'b1}}};
    end else if (x < -11'sd512) begin
      return {1'b1, {(Q_W-1){1'b0}}};
    end else begin
      return x[Q_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ov_debounce.sv
// Over-voltage debounce: counts consecutive switching periods in which the
// sampled output exceeds OV_LIMIT and emits a single-cycle ov_trip on the
// sw_tick that makes the run reach OV_COUNT.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : hold counter at zero (driven by the sequencer outside run states)
//   sw_tick   : one-clk pulse per switching period
//   n_out     : signed sampled output voltage code
//   ov_trip   : combinational trip pulse, valid in the sw_tick cycle
module ov_debounce
  import pid_ctrl_pkg::*;
#(
  parameter logic signed [Q_W-1:0] OV_LIMIT = OV_LIMIT_DEF,
  parameter int                    OV_COUNT = OV_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  sw_tick,
  input  logic signed [Q_W-1:0] n_out,
  output logic                  ov_trip
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       over;

  always_comb begin
    over    = (n_out > OV_LIMIT);
    cnt_d   = cnt_q;
    ov_trip = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (sw_tick) begin
      if (over) begin
        // The tick that completes the run trips and restarts the count.
        if (cnt_q == 4'(OV_COUNT - 1)) begin
          ov_trip = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pid_ref_sequencer.sv
// PID loop sequencer: soft-starts the reference from 0 to n_ref_nom, then
// runs periodic load/reference transients, and shuts the DPWM down on
// sustained over-voltage.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   sw_tick     : one-clk pulse per switching period
//   enable      : converter run request (level)
//   tran_type   : 0 = load transient, 1 = reference transient
//   n_ref_nom   : signed nominal reference code
//   delta_n_ref : signed reference step used by reference transients
//   n_out       : signed sampled output voltage code
//   n_ref       : signed reference to the PID error subtractor (registered)
//   q_load      : load-step switch drive (registered)
//   pwm_en      : DPWM gate enable (registered)
//   fault       : latched over-voltage flag (registered)
//   state       : current sequencer state (debug)
module pid_ref_sequencer
  import pid_ctrl_pkg::*;
#(
  parameter logic signed [Q_W-1:0] RAMP_STEP = RAMP_STEP_DEF,
  parameter int                    N_TRAN    = N_TRAN_DEF,
  parameter logic signed [Q_W-1:0] OV_LIMIT  = OV_LIMIT_DEF,
  parameter int                    OV_COUNT  = OV_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_tick,
  input  logic                  enable,
  input  logic                  tran_type,
  input  logic signed [Q_W-1:0] n_ref_nom,
  input  logic signed [Q_W-1:0] delta_n_ref,
  input  logic signed [Q_W-1:0] n_out,
  output logic signed [Q_W-1:0] n_ref,
  output logic                  q_load,
  output logic                  pwm_en,
  output logic                  fault,
  output logic [2:0]            state
);

  localparam int               CNT_W    = $clog2(N_TRAN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TRAN - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(N_TRAN / 2);

  seq_state_e            state_q, state_d;
  logic signed [Q_W-1:0] n_ref_q, n_ref_d;
  logic                  q_load_q, q_load_d;
  logic                  pwm_en_q, pwm_en_d;
  logic                  fault_q, fault_d;
  logic [CNT_W-1:0]      per_cnt_q, per_cnt_d;

  logic                  run;
  logic                  ov_trip;
  logic signed [Q_W:0]   nom_ext;
  logic signed [Q_W:0]   ramp_sum;
  logic signed [Q_W:0]   tran_sum;
  logic [CNT_W-1:0]      per_cnt_nxt;
  logic                  tran_active;

  assign run = (state_q == ST_SOFTSTART) || (state_q == ST_REGULATE);

  ov_debounce #(
    .OV_LIMIT (OV_LIMIT),
    .OV_COUNT (OV_COUNT)
  ) u_ov_debounce (
    .clk     (clk),
    .rst     (rst),
    .clr     (!run),
    .sw_tick (sw_tick),
    .n_out   (n_out),
    .ov_trip (ov_trip)
  );

  always_comb begin
    // 11-bit intermediates so neither the ramp nor the transient sum can wrap.
    nom_ext  = {n_ref_nom[Q_W-1], n_ref_nom};
    ramp_sum = {n_ref_q[Q_W-1], n_ref_q} + {RAMP_STEP[Q_W-1], RAMP_STEP};
    tran_sum = nom_ext + {delta_n_ref[Q_W-1], delta_n_ref};

    per_cnt_nxt = per_cnt_q;
    if (sw_tick) begin
      per_cnt_nxt = (per_cnt_q == CNT_LAST) ? '0 : per_cnt_q + CNT_W'(1);
    end
    tran_active = (per_cnt_nxt > CNT_HALF);

    state_d   = state_q;
    n_ref_d   = n_ref_q;
    q_load_d  = q_load_q;
    pwm_en_d  = pwm_en_q;
    fault_d   = fault_q;
    per_cnt_d = per_cnt_q;

    case (state_q)
      ST_IDLE: begin
        n_ref_d   = '0;
        q_load_d  = 1'b0;
        pwm_en_d  = 1'b0;
        fault_d   = 1'b0;
        per_cnt_d = '0;
        if (enable) begin
          state_d  = ST_SOFTSTART;
          pwm_en_d = 1'b1;
        end
      end

      ST_SOFTSTART, ST_REGULATE: begin
        if (ov_trip) begin
          state_d   = ST_FAULT;
          n_ref_d   = '0;
          q_load_d  = 1'b0;
          pwm_en_d  = 1'b0;
          fault_d   = 1'b1;
          per_cnt_d = '0;
        end else if (!enable) begin
          state_d   = ST_IDLE;
          n_ref_d   = '0;
          q_load_d  = 1'b0;
          pwm_en_d  = 1'b0;
          per_cnt_d = '0;
        end else if (state_q == ST_SOFTSTART) begin
          // min(n_ref + step, nom); a non-positive nominal lands on the first tick.
          if (sw_tick) begin
            if (ramp_sum >= nom_ext) begin
              state_d   = ST_REGULATE;
              n_ref_d   = n_ref_nom;
              q_load_d  = 1'b0;
              per_cnt_d = '0;
            end else begin
              n_ref_d = ramp_sum[Q_W-1:0];
            end
          end
        end else begin
          // Outputs follow the counter value being written this cycle, and
          // tran_type / n_ref_nom are re-sampled every clock.
          per_cnt_d = per_cnt_nxt;
          q_load_d  = tran_active && !tran_type;
          n_ref_d   = (tran_active && tran_type) ? sat10(tran_sum) : n_ref_nom;
        end
      end

      ST_FAULT: begin
        n_ref_d   = '0;
        q_load_d  = 1'b0;
        pwm_en_d  = 1'b0;
        per_cnt_d = '0;
        if (!enable) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        n_ref_d   = '0;
        q_load_d  = 1'b0;
        pwm_en_d  = 1'b0;
        fault_d   = 1'b0;
        per_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_ref_q   <= '0;
      q_load_q  <= 1'b0;
      pwm_en_q  <= 1'b0;
      fault_q   <= 1'b0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_ref_q   <= n_ref_d;
      q_load_q  <= q_load_d;
      pwm_en_q  <= pwm_en_d;
      fault_q   <= fault_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  assign n_ref  = n_ref_q;
  assign q_load = q_load_q;
  assign pwm_en = pwm_en_q;
  assign fault  = fault_q;
  assign state  = state_q;

endmodule

// File: tb/tb_pid_ref_sequencer.sv
// Directed bench for pid_ref_sequencer: a cycle-level reference model of the
// sequencing rules checked against the DUT every falling edge, plus literal
// expectations at key points of the ramp, transients, saturation and fault.
module tb_pid_ref_sequencer;

  logic              clk;
  logic              rst;
  logic              sw_tick;
  logic              enable;
  logic              tran_type;
  logic signed [9:0] n_ref_nom;
  logic signed [9:0] delta_n_ref;
  logic signed [9:0] n_out;
  logic signed [9:0] n_ref;
  logic              q_load;
  logic              pwm_en;
  logic              fault;
  logic [2:0]        state;

  int total = 0;
  int bad   = 0;

  pid_ref_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .sw_tick     (sw_tick),
    .enable      (enable),
    .tran_type   (tran_type),
    .n_ref_nom   (n_ref_nom),
    .delta_n_ref (delta_n_ref),
    .n_out       (n_out),
    .n_ref       (n_ref),
    .q_load      (q_load),
    .pwm_en      (pwm_en),
    .fault       (fault),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 idle, 1 ramping, 2 regulating, 3 faulted.
  int m_state, m_nref, m_qload, m_pwm, m_fault, m_cnt, m_ov;
  int nom, dl;
  bit trip, act;

  function automatic int clamp10(input int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_nref = 0; m_qload = 0; m_pwm = 0;
      m_fault = 0; m_cnt = 0; m_ov = 0;
    end else begin
      nom  = int'(n_ref_nom);
      dl   = int'(delta_n_ref);
      trip = 1'b0;
      if ((m_state == 1 || m_state == 2) && sw_tick) begin
        if (int'(n_out) > 400) m_ov = m_ov + 1;
        else m_ov = 0;
        if (m_ov >= 4) trip = 1'b1;
      end
      case (m_state)
        0: begin
          m_nref = 0; m_qload = 0; m_pwm = 0; m_fault = 0;
          if (enable) begin m_state = 1; m_pwm = 1; end
        end
        1, 2: begin
          if (trip) begin
            m_state = 3; m_fault = 1; m_pwm = 0; m_nref = 0; m_qload = 0;
            m_cnt = 0; m_ov = 0;
          end else if (!enable) begin
            m_state = 0; m_pwm = 0; m_nref = 0; m_qload = 0;
            m_cnt = 0; m_ov = 0;
          end else if (m_state == 1) begin
            if (sw_tick) begin
              m_nref = (m_nref + 2 < nom) ? m_nref + 2 : nom;
              if (m_nref == nom) begin m_state = 2; m_cnt = 0; m_qload = 0; end
            end
          end else begin
            if (sw_tick) m_cnt = (m_cnt + 1) % 100;
            act     = (m_cnt > 50);
            m_qload = (act && !tran_type) ? 1 : 0;
            m_nref  = (act && tran_type) ? clamp10(nom + dl) : nom;
          end
        end
        default: begin
          if (!enable) begin m_state = 0; m_fault = 0; end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cyc_n_ref",  int'(n_ref), m_nref);
    check("cyc_q_load", int'(q_load), m_qload);
    check("cyc_pwm_en", int'(pwm_en), m_pwm);
    check("cyc_fault",  int'(fault), m_fault);
    check("cyc_state",  int'(state), m_state);
  end

  // ---------------- stimulus ----------------
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sw_tick = 1'b1;
      @(negedge clk);
      sw_tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; sw_tick = 1'b0; enable = 1'b0; tran_type = 1'b1;
    n_ref_nom = 10'sd138; delta_n_ref = 10'sd14; n_out = 10'sd0;
    repeat (3) @(negedge clk);
    check("rst_n_ref", int'(n_ref), 0);
    check("rst_state", int'(state), 0);
    check("rst_pwm",   int'(pwm_en), 0);
    check("rst_fault", int'(fault), 0);
    rst = 1'b0;
    @(negedge clk);

    // Soft-start 0 -> 138 in steps of 2.
    enable = 1'b1;
    @(negedge clk);
    check("ss_pwm", int'(pwm_en), 1);
    ticks(1);
    check("ramp_first", int'(n_ref), 2);
    ticks(67);
    check("ramp_68", int'(n_ref), 136);
    check("ramp_68_state", int'(state), 1);
    ticks(1);
    check("ramp_done", int'(n_ref), 138);
    check("reg_state", int'(state), 2);

    // Reference transient: 152 while counter is 51..99.
    ticks(50);
    check("rt_c50", int'(n_ref), 138);
    ticks(1);
    check("rt_c51", int'(n_ref), 152);
    check("rt_qload", int'(q_load), 0);
    ticks(48);
    check("rt_c99", int'(n_ref), 152);
    ticks(1);
    check("rt_c0", int'(n_ref), 138);

    // Load transient.
    tran_type = 1'b0;
    ticks(51);
    check("lt_qload", int'(q_load), 1);
    check("lt_n_ref", int'(n_ref), 138);
    ticks(49);
    check("lt_qload_off", int'(q_load), 0);

    // Saturation.
    n_ref_nom = 10'sd500; delta_n_ref = 10'sd100; tran_type = 1'b1;
    @(negedge clk);
    check("sat_nom", int'(n_ref), 500);
    ticks(51);
    check("sat_511", int'(n_ref), 511);

    // Over-voltage: 3 ticks then a dip, no fault; then 4 in a row.
    n_out = 10'sd401;
    ticks(3);
    n_out = 10'sd399;
    ticks(1);
    check("ov_nofault", int'(fault), 0);
    n_out = 10'sd401;
    ticks(3);
    check("ov_3", int'(fault), 0);
    ticks(1);
    check("ov_fault", int'(fault), 1);
    check("ov_pwm", int'(pwm_en), 0);
    check("ov_n_ref", int'(n_ref), 0);
    check("ov_state", int'(state), 3);
    ticks(3);
    check("ov_latched", int'(fault), 1);
    enable = 1'b0; n_out = 10'sd0;
    @(negedge clk);
    check("ov_clear_state", int'(state), 0);
    check("ov_clear_fault", int'(fault), 0);

    // Enable drop mid-ramp, then restart from 0.
    n_ref_nom = 10'sd138; tran_type = 1'b1; delta_n_ref = 10'sd14;
    enable = 1'b1;
    @(negedge clk);
    ticks(10);
    check("drop_pre", int'(n_ref), 20);
    enable = 1'b0;
    @(negedge clk);
    check("drop_state", int'(state), 0);
    check("drop_n_ref", int'(n_ref), 0);
    enable = 1'b1;
    @(negedge clk);
    ticks(1);
    check("restart_n_ref", int'(n_ref), 2);

    // Reset mid reference transient takes effect without a clock edge.
    ticks(68);
    ticks(60);
    check("pre_rst_n_ref", int'(n_ref), 152);
    rst = 1'b1;
    #1;
    check("rst_async_n_ref", int'(n_ref), 0);
    check("rst_async_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ticks(1);
    check("rst_restart", int'(n_ref), 2);

    // Non-positive nominal loads directly on the first tick.
    enable = 1'b0;
    @(negedge clk);
    n_ref_nom = -10'sd20;
    enable = 1'b1;
    @(negedge clk);
    ticks(1);
    check("neg_nom_n_ref", int'(n_ref), -20);
    check("neg_nom_state", int'(state), 2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
